mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the 8-bit MIPS datapath. It holds the instruction-sequencing FSM and the ALU decoder, and it drives the 3-bit `alucontrol` code into the datapath ALU. It also drives every enable and mux select the datapath needs. Instructions are 32 bits and are fetched one byte per cycle into four instruction-register byte lanes, then decoded and executed over several further cycles.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `op`  in  6  instruction opcode, `instr[31:26]`; valid from DECODE onward
- `funct`  in  6  R-type function field, `instr[5:0]`
- `zero`  in  1  ALU zero flag
- `memwrite`  out  1  memory write strobe
- `alusrca`  out  1  ALU source A: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU source B: 00 = register B, 01 = constant 1, 10 = immediate, 11 = branch offset
- `memtoreg`  out  1  register write data: 0 = ALUOut, 1 = MDR
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `pcen`  out  1  PC load enable
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `regwrite`  out  1  register file write enable
- `regdst`  out  1  destination register: 0 = rt, 1 = rd
- `irwrite`  out  4  one-hot instruction-register byte-lane load
- `alucontrol`  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt

## Operation
- Moore FSM. Every output is a combinational function of the state. Exceptions: `pcen` also depends on `zero`, and `alucontrol` also depends on `funct`.
- Unless listed below, an output is 0 in every state.
- FETCH1–FETCH4:
  - iord=0, alusrca=0, alusrcb=01, add, pcsrc=00, pcen=1.
  - irwrite = 0001, 0010, 0100, 1000 respectively.
  - Transitions run FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
- DECODE: alusrca=0, alusrcb=11, add. This precomputes the branch target into ALUOut. Next state by op:
  - 100000 lb → MEMADR
  - 101000 sb → MEMADR
  - 000000 R-type → RTYPEEX
  - 000100 beq → BEQEX
  - 000010 j → JEX
  - 001000 addi → ADDIEX
  - any other op → FETCH1, with no architectural write.
- Load/store path:
  - MEMADR: alusrca=1, alusrcb=10, add. Next LBRD for lb, SBWR for sb.
  - LBRD: iord=1, then LBWR.
  - LBWR: regwrite=1, memtoreg=1, regdst=0, then FETCH1.
  - SBWR: iord=1, memwrite=1, then FETCH1.
- R-type path:
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct, then RTYPEWR.
  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0, then FETCH1.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero, then FETCH1.
- JEX: pcsrc=10, pcen=1, then FETCH1.
- Add-immediate path:
  - ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWR.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0, then FETCH1.
- ALU decode, by aluop:
  - aluop 00 → add.
  - aluop 01 → sub.
  - aluop 10 → by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct → add.
- Reset:
  - While `reset` is high, pcen, irwrite, regwrite and memwrite are forced to 0.
  - At the first clock edge with `reset` high, the state becomes FETCH1.
  - Reset in any state, including mid-fetch, aborts the instruction; no further write enables are issued.

## Timing
- One state per cycle. Cycles per instruction, FETCH1 through the last state inclusive:
  - lb: 8
  - sb, R-type, addi: 7
  - beq, j: 6
  - unknown op: 5
- Write enables are asserted for exactly one cycle per occurrence. The datapath samples them on the next rising edge.
- `op` and `funct` are read only in DECODE and later states. Their values during FETCH1–FETCH4 do not affect the outputs.
- `zero` is sampled combinationally in BEQEX only.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum
  - opcode and funct localparams
  - the alucontrol code constants
  - the 2-bit aluop type
- Sub-module `aludec` maps (aluop, funct) to alucontrol. It is purely combinational.
- The FSM, the next-state logic and the output decode live in `mc_controller`.

## Test plan
- Reset held 2 cycles, then released → state FETCH1. During reset, pcen=irwrite=regwrite=memwrite=0. After release, irwrite steps 0001→0010→0100→1000 and pcen=1 in each fetch cycle.
- op=000000, funct=101010 → RTYPEEX has alucontrol=111. RTYPEWR has regwrite=1, regdst=1. The next FETCH1 arrives 7 cycles after the start.
- op=100000 (lb) → sequence MEMADR (alusrcb=10), LBRD (iord=1), LBWR (regwrite=1, memtoreg=1). 8 cycles total.
- op=000100 (beq): with zero=1 → pcen=1, pcsrc=01 in BEQEX. With zero=0 → pcen=0. Both cases return to FETCH1.
- op=111111 (unknown) → DECODE goes straight to FETCH1, and no memwrite or regwrite pulse occurs.
- reset asserted during SBWR → memwrite is 0 in that cycle, and the next state is FETCH1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_FETCH4,
        S_DECODE,
        S_MEMADR,
        S_LBRD,
        S_LBWR,
        S_SBWR,
        S_RTYPEEX,
        S_RTYPEWR,
        S_BEQEX,
        S_JEX,
        S_ADDIEX,
        S_ADDIWR
    } state_t;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU function codes driven to the datapath
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Operation class handed from the FSM to the ALU decoder
    typedef logic [1:0] aluop_t;
    localparam aluop_t ALUOP_ADD   = 2'b00;
    localparam aluop_t ALUOP_SUB   = 2'b01;
    localparam aluop_t ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit alucontrol code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct field for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequencing FSM plus output and ALU decode.
// Latency: one state per cycle; 5-8 cycles per instruction depending on op.
// Backpressure: none; the datapath samples the enables on the next edge.
module mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       memtoreg,
    output logic       iord,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic [3:0] irwrite,
    output logic [2:0] alucontrol
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic       alu_used;
    logic [2:0] dec_alucontrol;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (dec_alucontrol)
    );

    // State register; reset lands in FETCH1 and abandons any instruction
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH1;
        else       state <= next_state;
    end

    // Next-state logic; op is only consulted from DECODE onward
    always_comb begin
        next_state = S_FETCH1;
        case (state)
            S_FETCH1:  next_state = S_FETCH2;
            S_FETCH2:  next_state = S_FETCH3;
            S_FETCH3:  next_state = S_FETCH4;
            S_FETCH4:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_J:         next_state = S_JEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH1;
                endcase
            end
            S_MEMADR:  next_state = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    next_state = S_LBWR;
            S_RTYPEEX: next_state = S_RTYPEWR;
            S_ADDIEX:  next_state = S_ADDIWR;
            default:   next_state = S_FETCH1;
        endcase
    end

    // Moore output decode; write enables are squashed while reset is high
    always_comb begin
        memwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        memtoreg = 1'b0;
        iord     = 1'b0;
        pcen     = 1'b0;
        pcsrc    = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        irwrite  = 4'b0000;
        aluop    = ALUOP_ADD;
        alu_used = 1'b0;
        case (state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                alusrcb  = 2'b01;
                pcen     = 1'b1;
                alu_used = 1'b1;
                irwrite  = 4'b0001 << (state - S_FETCH1);
            end
            S_DECODE: begin
                alusrcb  = 2'b11;
                alu_used = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                alu_used = 1'b1;
            end
            S_LBRD: iord = 1'b1;
            S_LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_SBWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_FUNCT;
                alu_used = 1'b1;
            end
            S_RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                alu_used = 1'b1;
                pcsrc    = 2'b01;
                pcen     = zero;
            end
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            S_ADDIWR: regwrite = 1'b1;
            default: ;
        endcase
        if (reset) begin
            pcen     = 1'b0;
            irwrite  = 4'b0000;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end
    end

    // Idle states present 000 rather than an arbitrary decoder result
    assign alucontrol = alu_used ? dec_alucontrol : 3'b000;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] irwrite;
    logic [2:0] alucontrol;

    int total = 0;
    int bad   = 0;

    typedef logic [17:0] vec_t;
    vec_t exp_q[$];

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memwrite   (memwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .memtoreg   (memtoreg),
        .iord       (iord),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .irwrite    (irwrite),
        .alucontrol (alucontrol)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic mw, input logic asa, input logic [1:0] asb,
                                input logic m2r, input logic io, input logic pe,
                                input logic [1:0] ps, input logic rw, input logic rd,
                                input logic [3:0] irw, input logic [2:0] ac);
        return {mw, asa, asb, m2r, io, pe, ps, rw, rd, irw, ac};
    endfunction

    // Expected per-state output vectors
    function automatic vec_t v_fetch(input int i);
        logic [3:0] irw;
        irw = 4'b0001 << i;
        return mk(0, 0, 2'b01, 0, 0, 1, 2'b00, 0, 0, irw, 3'b010);
    endfunction
    function automatic vec_t v_rst_f1();  return mk(0, 0, 2'b01, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 3'b010); endfunction
    function automatic vec_t v_decode();  return mk(0, 0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 3'b010); endfunction
    function automatic vec_t v_memadr();  return mk(0, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 4'b0000, 3'b010); endfunction
    function automatic vec_t v_lbrd();    return mk(0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 4'b0000, 3'b000); endfunction
    function automatic vec_t v_lbwr();    return mk(0, 0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 4'b0000, 3'b000); endfunction
    function automatic vec_t v_sbwr(input logic mw); return mk(mw, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0, 4'b0000, 3'b000); endfunction
    function automatic vec_t v_rtex(input logic [2:0] ac); return mk(0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 4'b0000, ac); endfunction
    function automatic vec_t v_rtwr();    return mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 1, 4'b0000, 3'b000); endfunction
    function automatic vec_t v_beq(input logic z); return mk(0, 1, 2'b00, 0, 0, z, 2'b01, 0, 0, 4'b0000, 3'b110); endfunction
    function automatic vec_t v_jex();     return mk(0, 0, 2'b00, 0, 0, 1, 2'b10, 0, 0, 4'b0000, 3'b000); endfunction
    function automatic vec_t v_addiwr();  return mk(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 4'b0000, 3'b000); endfunction

    function automatic vec_t observed();
        return {memwrite, alusrca, alusrcb, memtoreg, iord, pcen, pcsrc,
                regwrite, regdst, irwrite, alucontrol};
    endfunction

    task automatic push_fetch_decode();
        for (int i = 0; i < 4; i++) exp_q.push_back(v_fetch(i));
        exp_q.push_back(v_decode());
    endtask

    // Check the current cycle at negedge against the scoreboard head, then advance
    task automatic step(input string tag);
        vec_t e;
        @(negedge clk);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s obs=%h exp=queue_entry", tag, observed());
        end else begin
            e = exp_q.pop_front();
            assert (observed() === e) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", tag, observed(), e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drain the scoreboard; fetch cycles see inverted op/funct/zero, which must not matter
    task automatic run(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int reset_at);
        int n;
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            op    = (c < 4) ? ~o : o;
            funct = (c < 4) ? ~f : f;
            zero  = (c < 4) ? ~z : z;
            if (reset_at >= 0 && c >= reset_at) reset = 1'b1;
            step($sformatf("%s_c%0d", name, c));
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(v_rst_f1());
        exp_q.push_back(v_rst_f1());
        step("reset_c0");
        step("reset_c1");
        reset = 1'b0;

        // R-type slt
        push_fetch_decode();
        exp_q.push_back(v_rtex(3'b111));
        exp_q.push_back(v_rtwr());
        run("rtype_slt", 6'b000000, 6'b101010, 1'b0, -1);

        // remaining R-type functs, including an unknown one that decodes as add
        begin
            logic [5:0] fs[5];
            logic [2:0] acs[5];
            fs  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b111111};
            acs = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b010};
            for (int k = 0; k < 5; k++) begin
                push_fetch_decode();
                exp_q.push_back(v_rtex(acs[k]));
                exp_q.push_back(v_rtwr());
                run($sformatf("rtype_f%0d", k), 6'b000000, fs[k], 1'b0, -1);
            end
        end

        // lb
        push_fetch_decode();
        exp_q.push_back(v_memadr());
        exp_q.push_back(v_lbrd());
        exp_q.push_back(v_lbwr());
        run("lb", 6'b100000, 6'b000000, 1'b0, -1);

        // sb
        push_fetch_decode();
        exp_q.push_back(v_memadr());
        exp_q.push_back(v_sbwr(1'b1));
        run("sb", 6'b101000, 6'b000000, 1'b0, -1);

        // beq taken / not taken
        push_fetch_decode();
        exp_q.push_back(v_beq(1'b1));
        run("beq_z1", 6'b000100, 6'b000000, 1'b1, -1);
        push_fetch_decode();
        exp_q.push_back(v_beq(1'b0));
        run("beq_z0", 6'b000100, 6'b000000, 1'b0, -1);

        // j
        push_fetch_decode();
        exp_q.push_back(v_jex());
        run("j", 6'b000010, 6'b000000, 1'b0, -1);

        // addi
        push_fetch_decode();
        exp_q.push_back(v_memadr());
        exp_q.push_back(v_addiwr());
        run("addi", 6'b001000, 6'b000000, 1'b0, -1);

        // unknown op: back to FETCH1 straight from DECODE
        push_fetch_decode();
        run("unknown", 6'b111111, 6'b000000, 1'b0, -1);

        // reset raised in SBWR: memwrite squashed, then FETCH1 held under reset
        push_fetch_decode();
        exp_q.push_back(v_memadr());
        exp_q.push_back(v_sbwr(1'b0));
        exp_q.push_back(v_rst_f1());
        run("sb_reset", 6'b101000, 6'b000000, 1'b0, 6);

        // resumes with a normal fetch
        exp_q.push_back(v_fetch(0));
        exp_q.push_back(v_fetch(1));
        run("after_reset", 6'b000000, 6'b000000, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
